// File: rtl/im_arbiter_3cpu.sv
// -----------------------------------------------------------------------------
// im_arbiter_3cpu
//
// Shares one single-read-port instruction memory between three sr_cpu cores.
// Each core presents a word address and stalls until its one-cycle data-valid
// pulse arrives. The arbiter issues at most one read per cycle and picks the
// next core in round-robin order. It tracks reads through a fixed-latency
// memory with a tag pipe that is MEM_LATENCY stages deep.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   cpuEn[2:0]                per-core enable; a disabled core gets no new grants
//   imAddr0..2    [31:0]      per-core instruction word address, held until vld
//   imData0..2    [31:0]      instruction data, memData broadcast to all cores
//   imDataVld0..2             per-core one-cycle data-valid pulse
//   memAddr       [ADDR_W-1:0] memory read address, zero when idle
//   memRe                     memory read strobe
//   memData       [31:0]      memory read data, valid MEM_LATENCY cycles after memRe
//
// Parameters
//   ADDR_W       memory address width, at most 32 (low bits of imAddrN)
//   MEM_LATENCY  memory read latency in cycles, 1..8
// -----------------------------------------------------------------------------
module im_arbiter_3cpu #(
    parameter int ADDR_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        cpuEn,
    input  logic [31:0]       imAddr0,
    input  logic [31:0]       imAddr1,
    input  logic [31:0]       imAddr2,
    output logic [31:0]       imData0,
    output logic [31:0]       imData1,
    output logic [31:0]       imData2,
    output logic              imDataVld0,
    output logic              imDataVld1,
    output logic              imDataVld2,
    output logic [ADDR_W-1:0] memAddr,
    output logic              memRe,
    input  logic [31:0]       memData
);

    // Control state
    logic [1:0]             last_grant_q, last_grant_d;
    logic [2:0]             in_flight_q,  in_flight_d;
    logic [MEM_LATENCY-1:0] tag_vld_q,    tag_vld_d;

    // Tag identity travels next to its valid bit; it carries no reset
    logic [1:0]             tag_id_q [MEM_LATENCY];
    logic [1:0]             tag_id_d [MEM_LATENCY];

    logic                   ret_vld;
    logic [1:0]             ret_id;
    logic [2:0]             ret_onehot;
    logic [2:0]             eligible;
    logic [3:0]             eligible_pad;
    logic [1:0]             order [3];
    logic                   grant_vld;
    logic [1:0]             grant_id;
    logic [2:0]             grant_onehot;

    // ---- Return stage: tag leaving the pipe ----
    // Reset suppresses any return, so reads issued before reset never report back.
    assign ret_vld = tag_vld_q[MEM_LATENCY-1] & ~rst;
    assign ret_id  = tag_id_q[MEM_LATENCY-1];

    assign ret_onehot[0] = ret_vld && (ret_id == 2'd0);
    assign ret_onehot[1] = ret_vld && (ret_id == 2'd1);
    assign ret_onehot[2] = ret_vld && (ret_id == 2'd2);

    assign imDataVld0 = ret_onehot[0];
    assign imDataVld1 = ret_onehot[1];
    assign imDataVld2 = ret_onehot[2];

    assign imData0 = memData;
    assign imData1 = memData;
    assign imData2 = memData;

    // A core whose vld fires this cycle moves its PC at this edge. Its new
    // address only becomes visible next cycle, so it must not be granted now.
    assign eligible     = cpuEn & ~in_flight_q & ~ret_onehot;
    assign eligible_pad = {1'b0, eligible};

    // ---- Grant stage: round-robin pick, memory request ----
    always_comb begin
        case (last_grant_q)
            2'd0:    order = '{2'd1, 2'd2, 2'd0};
            2'd1:    order = '{2'd2, 2'd0, 2'd1};
            default: order = '{2'd0, 2'd1, 2'd2};
        endcase

        grant_vld = 1'b0;
        grant_id  = 2'd0;
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                if (!grant_vld && eligible_pad[order[k]]) begin
                    grant_vld = 1'b1;
                    grant_id  = order[k];
                end
            end
        end
    end

    assign grant_onehot[0] = grant_vld && (grant_id == 2'd0);
    assign grant_onehot[1] = grant_vld && (grant_id == 2'd1);
    assign grant_onehot[2] = grant_vld && (grant_id == 2'd2);

    always_comb begin
        memRe   = grant_vld;
        memAddr = '0;
        if (grant_vld) begin
            case (grant_id)
                2'd0:    memAddr = imAddr0[ADDR_W-1:0];
                2'd1:    memAddr = imAddr1[ADDR_W-1:0];
                default: memAddr = imAddr2[ADDR_W-1:0];
            endcase
        end
    end

    // ---- Next-state: arbitration pointer, in-flight set, tag pipe shift ----
    always_comb begin
        last_grant_d = grant_vld ? grant_id : last_grant_q;
        // A core never receives a grant and a return in the same cycle,
        // so clearing and setting its in-flight bit never collide.
        in_flight_d  = (in_flight_q & ~ret_onehot) | grant_onehot;

        tag_vld_d    = '0;
        tag_vld_d[0] = grant_vld;
        tag_id_d[0]  = grant_id;
        for (int i = 1; i < MEM_LATENCY; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_id_d[i]  = tag_id_q[i-1];
        end
    end

    // Starting at 2 makes core 0 the first winner after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 2'd2;
            in_flight_q  <= 3'b000;
            tag_vld_q    <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            in_flight_q  <= in_flight_d;
            tag_vld_q    <= tag_vld_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < MEM_LATENCY; i++) begin
            tag_id_q[i] <= tag_id_d[i];
        end
    end

endmodule

// File: tb/tb_im_arbiter_3cpu.sv
module tb_im_arbiter_3cpu;

    logic        clk;
    logic        rst;
    logic [2:0]  cpu_en;
    logic [31:0] a0, a1, a2;

    // Per-latency observation arrays (index 0/1/2 -> MEM_LATENCY 1/2/3)
    logic        re_a   [3];
    logic [31:0] addr_a [3];
    logic [2:0]  vld_a  [3];
    logic [31:0] d0_a   [3];
    logic [31:0] d1_a   [3];
    logic [31:0] d2_a   [3];
    logic [31:0] md_a   [3];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model state per instance: due cycle of each core's outstanding read (-1 = idle)
    int          m_last [3];
    int          m_due  [3][3];
    logic [31:0] m_addr [3][3];

    // Logs of DUT behaviour for the literal checks
    logic        dre   [3][128];
    logic [31:0] daddr [3][128];
    logic [2:0]  dvld  [3][128];
    logic [31:0] ddat  [3][128];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    genvar g;
    for (g = 0; g < 3; g++) begin : g_lat
        localparam int L = g + 1;
        logic        re_l;
        logic [31:0] addr_l;
        logic        v0, v1, v2;
        logic [31:0] d0, d1, d2;
        logic [31:0] md;
        logic [31:0] mpipe [L];

        im_arbiter_3cpu #(.ADDR_W(32), .MEM_LATENCY(L)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .cpuEn      (cpu_en),
            .imAddr0    (a0),
            .imAddr1    (a1),
            .imAddr2    (a2),
            .imData0    (d0),
            .imData1    (d1),
            .imData2    (d2),
            .imDataVld0 (v0),
            .imDataVld1 (v1),
            .imDataVld2 (v2),
            .memAddr    (addr_l),
            .memRe      (re_l),
            .memData    (md)
        );

        // Memory: word at address A holds A+100, delivered L cycles after the read
        always @(posedge clk) begin
            mpipe[0] <= re_l ? (addr_l + 32'd100) : 32'hBAD0_0000;
            for (int i = 1; i < L; i++) mpipe[i] <= mpipe[i-1];
        end
        assign md = mpipe[L-1];

        assign re_a[g]   = re_l;
        assign addr_a[g] = addr_l;
        assign vld_a[g]  = {v2, v1, v0};
        assign d0_a[g]   = d0;
        assign d1_a[g]   = d1;
        assign d2_a[g]   = d2;
        assign md_a[g]   = md;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] addr_of(input int n);
        if (n == 0) return a0;
        if (n == 1) return a1;
        return a2;
    endfunction

    task automatic model_reset();
        for (int li = 0; li < 3; li++) begin
            m_last[li] = 2;
            for (int n = 0; n < 3; n++) m_due[li][n] = -1;
        end
    endtask

    // Sample every instance mid-cycle, compare with the model, then advance the model.
    task automatic check_cycle();
        logic [2:0]  ev;
        int          gid;
        int          n;
        logic [31:0] ea;
        string       tg;
        for (int li = 0; li < 3; li++) begin
            ev  = 3'b000;
            gid = -1;
            if (!rst) begin
                for (int c = 0; c < 3; c++)
                    if (m_due[li][c] == cyc) ev[c] = 1'b1;
                for (int k = 1; k <= 3; k++) begin
                    n = (m_last[li] + k) % 3;
                    if (gid < 0 && cpu_en[n] && m_due[li][n] < 0) gid = n;
                end
            end
            ea = (gid >= 0) ? addr_of(gid) : 32'd0;
            tg = $sformatf("L%0d c%0d", li + 1, cyc);

            chk({tg, " memRe"},   {31'd0, re_a[li]}, {31'd0, gid >= 0});
            chk({tg, " memAddr"}, addr_a[li], ea);
            chk({tg, " vld"},     {29'd0, vld_a[li]}, {29'd0, ev});
            for (int c = 0; c < 3; c++)
                if (ev[c]) chk({tg, $sformatf(" data%0d", c)}, md_a[li], m_addr[li][c] + 32'd100);
            chk({tg, " imData0"}, d0_a[li], md_a[li]);
            chk({tg, " imData1"}, d1_a[li], md_a[li]);
            chk({tg, " imData2"}, d2_a[li], md_a[li]);

            dre[li][cyc]   = re_a[li];
            daddr[li][cyc] = addr_a[li];
            dvld[li][cyc]  = vld_a[li];
            ddat[li][cyc]  = d0_a[li];

            if (rst) begin
                m_last[li] = 2;
                for (int c = 0; c < 3; c++) m_due[li][c] = -1;
            end else begin
                for (int c = 0; c < 3; c++) if (ev[c]) m_due[li][c] = -1;
                if (gid >= 0) begin
                    m_due[li][gid]  = cyc + li + 1;
                    m_addr[li][gid] = addr_of(gid);
                    m_last[li]      = gid;
                end
            end
        end
        cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    int sA, sB, sC, sD, cnt;
    logic [31:0] exp_a [3];

    initial begin
        rst = 1'b1; cpu_en = 3'b000; a0 = 0; a1 = 0; a2 = 0;
        model_reset();

        // Scenario A: all cores enabled, addresses 10/20/30
        tick(); tick();
        rst = 1'b0; cpu_en = 3'b111; a0 = 10; a1 = 20; a2 = 30;
        sA = cyc;
        repeat (12) tick();

        // Scenario B: only core 1 enabled
        rst = 1'b1; tick();
        rst = 1'b0; cpu_en = 3'b010; a1 = 44;
        sB = cyc;
        repeat (8) tick();

        // Scenario C: reset pulse with two reads in flight
        rst = 1'b1; tick();
        rst = 1'b0; cpu_en = 3'b111; a0 = 10; a1 = 20; a2 = 30;
        sC = cyc;
        tick(); tick();
        rst = 1'b1; tick();
        rst = 1'b0;
        repeat (6) tick();

        // Scenario D: core 1 disabled the cycle after its grant
        rst = 1'b1; tick();
        rst = 1'b0; cpu_en = 3'b111; a0 = 11; a1 = 21; a2 = 31;
        sD = cyc;
        tick(); tick();
        cpu_en = 3'b101;
        repeat (10) tick();

        // Hand-computed expectations
        chk("rst memRe L1", {31'd0, dre[0][0]}, 32'd0);
        chk("rst vld L1",   {29'd0, dvld[0][0]}, 32'd0);
        chk("rst vld L3",   {29'd0, dvld[2][1]}, 32'd0);

        exp_a[0] = 10; exp_a[1] = 20; exp_a[2] = 30;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("A L1 re k%0d", k),   {31'd0, dre[0][sA+k]}, 32'd1);
            chk($sformatf("A L1 addr k%0d", k), daddr[0][sA+k], exp_a[k%3]);
        end
        chk("A L1 vld0 first",  {29'd0, dvld[0][sA+1]}, 32'd1);
        chk("A L1 data0 first", ddat[0][sA+1], 32'd110);
        chk("A L1 vld0 second", {29'd0, dvld[0][sA+4]}, 32'd1);
        chk("A L2 addr k3",     daddr[1][sA+3], 32'd10);
        for (int k = 0; k < 3; k++)
            chk($sformatf("A L3 addr k%0d", k), daddr[2][sA+k], exp_a[k]);
        chk("A L3 re c3",   {31'd0, dre[2][sA+3]}, 32'd0);
        chk("A L3 vld c3",  {29'd0, dvld[2][sA+3]}, 32'd1);
        chk("A L3 re c4",   {31'd0, dre[2][sA+4]}, 32'd1);
        chk("A L3 addr c4", daddr[2][sA+4], 32'd10);
        chk("A L3 vld c4",  {29'd0, dvld[2][sA+4]}, 32'd2);
        chk("A L3 vld c5",  {29'd0, dvld[2][sA+5]}, 32'd4);

        for (int k = 0; k < 8; k++)
            chk($sformatf("B L1 re k%0d", k), {31'd0, dre[0][sB+k]}, (k % 2 == 0) ? 32'd1 : 32'd0);
        chk("B L1 addr",  daddr[0][sB], 32'd44);
        chk("B L3 re c3", {31'd0, dre[2][sB+3]}, 32'd0);
        chk("B L3 re c4", {31'd0, dre[2][sB+4]}, 32'd1);

        chk("C L2 re rst",   {31'd0, dre[1][sC+2]}, 32'd0);
        chk("C L2 vld rst",  {29'd0, dvld[1][sC+2]}, 32'd0);
        chk("C L2 re post",  {31'd0, dre[1][sC+3]}, 32'd1);
        chk("C L2 addr post", daddr[1][sC+3], 32'd10);
        chk("C L2 vld post", {29'd0, dvld[1][sC+3]}, 32'd0);
        chk("C L2 vld c4",   {29'd0, dvld[1][sC+4]}, 32'd0);
        chk("C L2 vld c5",   {29'd0, dvld[1][sC+5]}, 32'd1);

        chk("D L2 grant1",  daddr[1][sD+1], 32'd21);
        chk("D L2 vld1",    {29'd0, dvld[1][sD+3]}, 32'd2);
        chk("D L2 data1",   ddat[1][sD+3], 32'd121);
        chk("D L2 addr c2", daddr[1][sD+2], 32'd31);
        chk("D L2 addr c3", daddr[1][sD+3], 32'd11);
        chk("D L2 re c4",   {31'd0, dre[1][sD+4]}, 32'd0);
        chk("D L2 addr c5", daddr[1][sD+5], 32'd31);
        chk("D L2 addr c6", daddr[1][sD+6], 32'd11);
        cnt = 0;
        for (int c = sD + 2; c < sD + 12; c++)
            if (dre[1][c] && daddr[1][c] == 32'd21) cnt++;
        chk("D L2 core1 regrants", cnt, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
